// File: rtl/n64adv2_igr_trigger_pkg.sv
// ---------------------------------------------------------------------------
// n64adv2_igr_trigger_pkg
//   Shared definitions for the in-game-reset trigger stage:
//   - igr_state_e      : FSM state encoding, also exported on the debug bus
//   - IGR_COMBO_DEFAULT: default button combo (Z + Start + L + R)
//   - TOUT_CNT_MAX     : saturation value of the 20-bit poll timeout counter
//   - combo_match()    : masked compare of the button half of a controller word
// ---------------------------------------------------------------------------
package n64adv2_igr_trigger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARM     = 2'b01,
        ST_DRIVE   = 2'b10,
        ST_RELEASE = 2'b11
    } igr_state_e;

    localparam logic [15:0] IGR_COMBO_DEFAULT = 16'h0C0C;
    localparam logic [19:0] TOUT_CNT_MAX      = 20'hFFFFF;

    function automatic logic combo_match(
        input logic [15:0] buttons,
        input logic [15:0] combo,
        input logic [15:0] mask
    );
        return ((buttons ^ combo) & mask) == 16'h0000;
    endfunction

endpackage

// File: rtl/n64adv2_igr_trigger.sv
// ---------------------------------------------------------------------------
// n64adv2_igr_trigger
//   In-game-reset trigger. Watches each freshly captured controller word and,
//   once the IGR combo has been held for HOLD_POLLS consecutive polls, drives
//   the N64 reset request for RST_LEN cycles. Afterwards it waits in
//   ST_RELEASE until the combo is let go (or the controller disappears) so a
//   held combo cannot re-trigger.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for the first qualified combo poll
//   ST_ARM     | combo seen on hold_cnt consecutive polls, counting up
//   ST_DRIVE   | reset request active, rst_cnt counts down to 0
//   ST_RELEASE | pulse done, waiting for combo release or poll timeout
//
// Ports
//   CTRL_CLK        : sniffer clock (4 MHz)
//   CTRL_nRST       : asynchronous active-low reset
//   igr_en_i        : IGR enable (synchronous to CTRL_CLK)
//   ctrl_detected_i : controller present
//   ctrl_data_i     : latest controller word, [15:0] = buttons
//   ctrl_valid_i    : one-cycle strobe, ctrl_data_i updated this cycle
//   drv_rst_o       : high while the N64 reset line must be pulled low
//   trig_o          : one-cycle pulse on entry into ST_DRIVE
//   igr_state_o     : current FSM state (debug bus)
// ---------------------------------------------------------------------------
module n64adv2_igr_trigger
    import n64adv2_igr_trigger_pkg::*;
#(
    parameter logic [15:0] IGR_COMBO    = IGR_COMBO_DEFAULT,
    parameter logic [15:0] COMBO_MASK   = 16'hFFFF,
    parameter logic [7:0]  HOLD_POLLS   = 8'd30,
    parameter logic [19:0] RST_LEN      = 20'hFFFFF,
    parameter logic [19:0] POLL_TIMEOUT = 20'd400000
) (
    input  logic        CTRL_CLK,
    input  logic        CTRL_nRST,
    input  logic        igr_en_i,
    input  logic        ctrl_detected_i,
    input  logic [31:0] ctrl_data_i,
    input  logic        ctrl_valid_i,
    output logic        drv_rst_o,
    output logic        trig_o,
    output logic [1:0]  igr_state_o
);

    igr_state_e  state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [19:0] rst_cnt_q, rst_cnt_d;
    logic [19:0] tout_cnt_q;
    logic        drv_rst_q;
    logic        trig_q;

    logic        match;
    logic        qual_match;
    logic        tout;

    // Only the button half of the controller word takes part in the compare.
    logic        unused_ctrl_hi;
    assign unused_ctrl_hi = ^ctrl_data_i[31:16];

    assign match      = combo_match(ctrl_data_i[15:0], IGR_COMBO, COMBO_MASK);
    assign qual_match = ctrl_valid_i & match & igr_en_i & ctrl_detected_i;

    // A strobe in the same cycle always beats the timeout: a valid poll
    // never counts as a lost controller.
    assign tout = ~ctrl_valid_i & (tout_cnt_q >= POLL_TIMEOUT);

    always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            tout_cnt_q <= 20'd0;
        end else if (ctrl_valid_i) begin
            tout_cnt_q <= 20'd0;
        end else if (tout_cnt_q != TOUT_CNT_MAX) begin
            tout_cnt_q <= tout_cnt_q + 20'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rst_cnt_d  = rst_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                hold_cnt_d = 8'd0;
                if (qual_match) begin
                    if (HOLD_POLLS == 8'd1) begin
                        state_d   = ST_DRIVE;
                        rst_cnt_d = RST_LEN - 20'd1;
                    end else begin
                        state_d    = ST_ARM;
                        hold_cnt_d = 8'd1;
                    end
                end
            end

            ST_ARM: begin
                if (!igr_en_i || tout) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 8'd0;
                end else if (ctrl_valid_i && !match) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = 8'd0;
                end else if (qual_match) begin
                    if (hold_cnt_q == HOLD_POLLS - 8'd1) begin
                        state_d    = ST_DRIVE;
                        hold_cnt_d = 8'd0;
                        rst_cnt_d  = RST_LEN - 20'd1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end

            // Enable, polls and timeout are ignored: a started reset completes.
            ST_DRIVE: begin
                if (rst_cnt_q == 20'd0) begin
                    state_d = ST_RELEASE;
                end else begin
                    rst_cnt_d = rst_cnt_q - 20'd1;
                end
            end

            ST_RELEASE: begin
                if ((ctrl_valid_i && !match) || tout) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 8'd0;
                rst_cnt_d  = 20'd0;
            end
        endcase
    end

    always_ff @(posedge CTRL_CLK or negedge CTRL_nRST) begin
        if (!CTRL_nRST) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 8'd0;
            rst_cnt_q  <= 20'd0;
            drv_rst_q  <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            // Decoded from the next state so both outputs rise on the same
            // edge that enters ST_DRIVE.
            drv_rst_q  <= (state_d == ST_DRIVE);
            trig_q     <= (state_d == ST_DRIVE) && (state_q != ST_DRIVE);
        end
    end

    assign drv_rst_o   = drv_rst_q;
    assign trig_o      = trig_q;
    assign igr_state_o = state_q;

endmodule

// File: tb/tb_n64adv2_igr_trigger.sv
module tb_n64adv2_igr_trigger;

    localparam logic [15:0] COMBO = 16'h0C0C;
    localparam logic [15:0] MASK  = 16'h0FFF;
    localparam int          HOLD  = 4;
    localparam int          RLEN  = 20;
    localparam int          TOUT  = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        det = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = 32'd0;
    logic        drv;
    logic        trig;
    logic [1:0]  st;

    n64adv2_igr_trigger #(
        .IGR_COMBO    (COMBO),
        .COMBO_MASK   (MASK),
        .HOLD_POLLS   (8'(HOLD)),
        .RST_LEN      (20'(RLEN)),
        .POLL_TIMEOUT (20'(TOUT))
    ) dut (
        .CTRL_CLK        (clk),
        .CTRL_nRST       (rst_n),
        .igr_en_i        (en),
        .ctrl_detected_i (det),
        .ctrl_data_i     (data),
        .ctrl_valid_i    (valid),
        .drv_rst_o       (drv),
        .trig_o          (trig),
        .igr_state_o     (st)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 counting held polls, 2 pulsing, 3 waiting for release
    int m_mode   = 0;
    int m_held   = 0;
    int m_remain = 0;
    int m_idle   = 0;
    int e_drv    = 0;
    int e_trig   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_match(input logic [31:0] d);
        return ((d[15:0] ^ COMBO) & MASK) == 16'h0000;
    endfunction

    task automatic start_pulse();
        m_mode   = 2;
        m_remain = RLEN;
        e_trig   = 1;
    endtask

    task automatic model_step();
        bit m, q, to;
        m  = is_match(data);
        q  = valid && m && en && det;
        to = !valid && (m_idle >= TOUT);
        e_trig = 0;
        case (m_mode)
            0: if (q) begin
                   if (HOLD == 1) start_pulse();
                   else begin m_mode = 1; m_held = 1; end
               end
            1: begin
                   if (!en || to) m_mode = 0;
                   else if (valid && !m) m_mode = 0;
                   else if (q) begin
                       m_held++;
                       if (m_held == HOLD) start_pulse();
                   end
               end
            2: begin
                   m_remain--;
                   if (m_remain == 0) m_mode = 3;
               end
            default: if ((valid && !m) || to) m_mode = 0;
        endcase
        m_idle = valid ? 0 : m_idle + 1;
        e_drv  = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_held = 0; m_remain = 0; m_idle = 0; e_drv = 0; e_trig = 0;
    endtask

    // One clock: model advances on the same edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("state", int'(st), m_mode);
        check("drv_rst", int'(drv), e_drv);
        check("trig", int'(trig), e_trig);
    endtask

    task automatic poll(input logic [31:0] d, input int gap);
        data  = d;
        valid = 1'b1;
        cycle();
        valid = 1'b0;
        repeat (gap) cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic trigger_now();
        for (int i = 0; i < HOLD - 1; i++) poll({16'hABCD, COMBO}, 2);
        poll({16'h1234, COMBO}, 0);
    endtask

    // Called right after the triggering poll; counts high cycles incl. the current one.
    task automatic measure_pulse(output int width, output int trigs);
        int guard;
        width = drv ? 1 : 0;
        trigs = trig ? 1 : 0;
        guard = 0;
        while (drv && guard < 200) begin
            cycle();
            guard++;
            if (drv)  width++;
            if (trig) trigs++;
        end
    endtask

    initial begin
        int w, tc;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int w, tc;
        logic [31:0] d;
        int gap;

        #20;
        check("rst_state", int'(st), 0);
        check("rst_drv", int'(drv), 0);
        check("rst_trig", int'(trig), 0);
        en  = 1'b1;
        det = 1'b1;
        #2 rst_n = 1'b1;

        // basic trigger
        idle(3);
        trigger_now();
        check("trig_latency", int'(trig), 1);
        check("drv_latency", int'(drv), 1);
        check("drive_state", int'(st), 2);
        measure_pulse(w, tc);
        check("pulse_len", w, RLEN);
        check("trig_count", tc, 1);
        check("after_pulse_state", int'(st), 3);

        // release lockout, then re-trigger
        poll({16'h0, COMBO}, 2);
        poll({16'h0, COMBO}, 0);
        check("lockout_state", int'(st), 3);
        poll(32'h0, 0);
        check("lockout_release", int'(st), 0);
        trigger_now();
        check("retrigger", int'(trig), 1);
        measure_pulse(w, tc);
        check("retrigger_len", w, RLEN);

        // timeout out of release
        poll({16'h0, COMBO}, 0);
        idle(TOUT);
        check("tout_release_pre", int'(st), 3);
        idle(1);
        check("tout_release", int'(st), 0);

        // broken hold
        for (int i = 0; i < HOLD - 1; i++) poll({16'h0, COMBO}, 2);
        check("broken_arm", int'(st), 1);
        poll(32'h0, 0);
        check("broken_idle", int'(st), 0);
        check("broken_drv", int'(drv), 0);

        // timeout out of arm
        poll({16'h0, COMBO}, 0);
        idle(TOUT);
        check("tout_arm_pre", int'(st), 1);
        idle(1);
        check("tout_arm", int'(st), 0);

        // strobe in the timeout cycle wins
        poll({16'h0, COMBO}, TOUT);
        poll({16'h0, COMBO}, 0);
        check("valid_beats_tout", int'(st), 1);
        poll(32'h0, 1);

        // enable interlock
        poll({16'h0, COMBO}, 1);
        en = 1'b0;
        cycle();
        check("en_drop_arm", int'(st), 0);
        en = 1'b1;
        for (int i = 0; i < HOLD - 1; i++) poll({16'h0, COMBO}, 1);
        en = 1'b0;
        poll({16'h0, COMBO}, 0);
        check("en_final_state", int'(st), 0);
        check("en_final_trig", int'(trig), 0);
        en = 1'b1;
        trigger_now();
        en = 1'b0;
        measure_pulse(w, tc);
        check("en_drop_drive_len", w, RLEN);
        en = 1'b1;
        poll(32'h0, 1);

        // mask and presence
        poll({16'hFFFF, COMBO ^ 16'hF000}, 0);
        check("mask_dontcare", int'(st), 1);
        poll({16'h0, COMBO ^ 16'h0001}, 0);
        check("mask_active", int'(st), 0);
        det = 1'b0;
        poll({16'h0, COMBO}, 0);
        check("no_ctrl", int'(st), 0);
        det = 1'b1;

        // asynchronous reset mid-pulse
        trigger_now();
        idle(5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_drv", int'(drv), 0);
        check("async_rst_state", int'(st), 0);
        check("async_rst_trig", int'(trig), 0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // randomized polls
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: d = {16'($urandom), COMBO ^ (16'($urandom) & ~MASK)};
                6:                d = 32'h0;
                default:          d = $urandom;
            endcase
            en  = ($urandom_range(0, 24) != 0);
            det = ($urandom_range(0, 24) != 0);
            gap = ($urandom_range(0, 19) == 0) ? TOUT + 5 : int'($urandom_range(0, 6));
            poll(d, gap);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
